// File: rtl/spi_apb_pkg.sv
// Shared definitions for the SPI-controller APB sequencer and its bench:
// register map, status bits and state encodings.
package spi_apb_pkg;

  localparam logic [2:0] ADDR_CR1 = 3'd0;
  localparam logic [2:0] ADDR_CR2 = 3'd1;
  localparam logic [2:0] ADDR_BR  = 3'd2;
  localparam logic [2:0] ADDR_SR  = 3'd3;
  localparam logic [2:0] ADDR_DR  = 3'd5;

  localparam int SR_SPTEF = 5;
  localparam int SR_SPIF  = 7;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_CR1, S_CFG_CR2, S_CFG_BR, S_READY,
    S_POLL_TE, S_WR_DR, S_POLL_IF, S_RD_DR
  } seq_state_e;

  typedef enum logic [1:0] {X_IDLE, X_SETUP, X_ACCESS, X_GAP} xfer_state_e;

  // States in which the sequencer owns an APB transfer.
  function automatic logic is_xfer_state(input seq_state_e s);
    return (s != S_IDLE) && (s != S_READY);
  endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// Single APB transfer engine: SETUP, ACCESS (until PREADY or timeout), then
// one forced idle cycle. A new start is accepted in that idle cycle.
module apb_master_xfer
  import spi_apb_pkg::*;
#(
  parameter int PREADY_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [2:0] addr_i,
  input  logic       write_i,
  input  logic [7:0] wdata_i,
  output logic       free_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] rdata_o,
  output logic [2:0] paddr_o,
  output logic       psel_o,
  output logic       penable_o,
  output logic       pwrite_o,
  output logic [7:0] pwdata_o,
  input  logic [7:0] prdata_i,
  input  logic       pready_i,
  input  logic       pslverr_i
);

  localparam int TW = $clog2(PREADY_TIMEOUT + 1);

  xfer_state_e   st_q;
  logic [TW-1:0] tmo_q;
  logic          done_q, err_q;
  logic [7:0]    rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q      <= X_IDLE;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      paddr_o   <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      pwdata_o  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (st_q)
        X_IDLE, X_GAP: begin
          if (start_i) begin
            st_q     <= X_SETUP;
            psel_o   <= 1'b1;
            paddr_o  <= addr_i;
            pwrite_o <= write_i;
            pwdata_o <= wdata_i;
          end else begin
            st_q <= X_IDLE;
          end
        end
        X_SETUP: begin
          st_q      <= X_ACCESS;
          penable_o <= 1'b1;
          tmo_q     <= '0;
        end
        X_ACCESS: begin
          // A timed-out transfer is dropped exactly like a completed one.
          if (pready_i || tmo_q == TW'(PREADY_TIMEOUT - 1)) begin
            st_q      <= X_GAP;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= pready_i ? pslverr_i : 1'b1;
            if (pready_i && !pwrite_o) rdata_q <= prdata_i;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: st_q <= X_IDLE;
      endcase
    end
  end

  assign free_o  = (st_q == X_IDLE) || (st_q == X_GAP);
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_apb_sequencer.sv
// APB master that configures the SPI controller, then streams bytes through
// it: poll SPTEF, write DR, poll SPIF, read DR back.
module spi_apb_sequencer
  import spi_apb_pkg::*;
#(
  parameter int POLL_MAX       = 255,
  parameter int PREADY_TIMEOUT = 16,
  parameter int SPTEF_BIT      = SR_SPTEF,
  parameter int SPIF_BIT       = SR_SPIF
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       cfg_start_i,
  input  logic [7:0] cfg_cr1_i,
  input  logic [7:0] cfg_cr2_i,
  input  logic [7:0] cfg_br_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       cfg_done_o,
  output logic       err_o,
  output logic [2:0] PADDR_o,
  output logic       PSEL_o,
  output logic       PENABLE_o,
  output logic       PWRITE_o,
  output logic [7:0] PWDATA_o,
  input  logic [7:0] PRDATA_i,
  input  logic       PREADY_i,
  input  logic       PSLVERR_i
);

  localparam int PW = $clog2(POLL_MAX + 1);

  seq_state_e    state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [7:0]    tx_q, tx_d, rx_q;
  logic          err_q, err_d, rdy_q, busy_q;

  logic       x_start, x_free, x_done, x_err, x_write;
  logic [2:0] x_addr;
  logic [7:0] x_wdata, x_rdata;

  always_comb begin
    state_d = state_q;
    poll_d  = poll_q;
    tx_d    = tx_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (cfg_start_i) begin
        state_d = S_CFG_CR1;
        err_d   = 1'b0;
      end
      S_READY: if (tx_valid_i) begin
        state_d = S_POLL_TE;
        tx_d    = tx_data_i;
        poll_d  = '0;
      end
      default: if (x_done) begin
        if (x_err) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          case (state_q)
            S_CFG_CR1: state_d = S_CFG_CR2;
            S_CFG_CR2: state_d = S_CFG_BR;
            S_CFG_BR:  state_d = S_READY;
            S_POLL_TE: begin
              if (x_rdata[SPTEF_BIT]) state_d = S_WR_DR;
              else if (poll_q == PW'(POLL_MAX - 1)) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
              end else poll_d = poll_q + 1'b1;
            end
            S_WR_DR: begin
              state_d = S_POLL_IF;
              poll_d  = '0;
            end
            S_POLL_IF: begin
              if (x_rdata[SPIF_BIT]) state_d = S_RD_DR;
              else if (poll_q == PW'(POLL_MAX - 1)) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
              end else poll_d = poll_q + 1'b1;
            end
            S_RD_DR: state_d = S_READY;
            default: ;
          endcase
        end
      end
    endcase
  end

  // Request is decoded from the next state so a follow-on transfer can
  // launch from the engine's idle cycle without a bubble.
  always_comb begin
    x_addr  = ADDR_SR;
    x_write = 1'b0;
    x_wdata = 8'h00;
    case (state_d)
      S_CFG_CR1: begin x_addr = ADDR_CR1; x_write = 1'b1; x_wdata = cfg_cr1_i; end
      S_CFG_CR2: begin x_addr = ADDR_CR2; x_write = 1'b1; x_wdata = cfg_cr2_i; end
      S_CFG_BR:  begin x_addr = ADDR_BR;  x_write = 1'b1; x_wdata = cfg_br_i;  end
      S_WR_DR:   begin x_addr = ADDR_DR;  x_write = 1'b1; x_wdata = tx_d;      end
      S_RD_DR:   x_addr = ADDR_DR;
      default: ;
    endcase
  end

  assign x_start = x_free && is_xfer_state(state_d);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      poll_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      tx_q    <= tx_d;
      err_q   <= err_d;
      rdy_q   <= (state_d == S_READY);
      busy_q  <= is_xfer_state(state_d);
      if (rx_valid_o) rx_q <= x_rdata;
    end
  end

  assign rx_valid_o = x_done && !x_err && (state_q == S_RD_DR);
  assign rx_data_o  = rx_valid_o ? x_rdata : rx_q;
  assign tx_ready_o = rdy_q;
  assign cfg_done_o = rdy_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

  apb_master_xfer #(.PREADY_TIMEOUT(PREADY_TIMEOUT)) u_xfer (
    .clk_i     (PCLK),
    .rst_i     (PRESET),
    .start_i   (x_start),
    .addr_i    (x_addr),
    .write_i   (x_write),
    .wdata_i   (x_wdata),
    .free_o    (x_free),
    .done_o    (x_done),
    .err_o     (x_err),
    .rdata_o   (x_rdata),
    .paddr_o   (PADDR_o),
    .psel_o    (PSEL_o),
    .penable_o (PENABLE_o),
    .pwrite_o  (PWRITE_o),
    .pwdata_o  (PWDATA_o),
    .prdata_i  (PRDATA_i),
    .pready_i  (PREADY_i),
    .pslverr_i (PSLVERR_i)
  );

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// Bench: an APB slave that replays scripted SR/DR values, a queue of the bus
// transactions the sequence must produce, and per-cycle protocol checks.
module tb_spi_apb_sequencer;
  import spi_apb_pkg::*;

  logic       PCLK = 1'b0, PRESET = 1'b1;
  logic       cfg_start_i = 1'b0, tx_valid_i = 1'b0;
  logic [7:0] cfg_cr1_i = '0, cfg_cr2_i = '0, cfg_br_i = '0, tx_data_i = '0;
  logic       tx_ready_o, rx_valid_o, busy_o, cfg_done_o, err_o;
  logic [7:0] rx_data_o, PWDATA_o, PRDATA_i;
  logic [2:0] PADDR_o;
  logic       PSEL_o, PENABLE_o, PWRITE_o, PREADY_i, PSLVERR_i;

  always #5 PCLK = ~PCLK;

  spi_apb_sequencer #(.POLL_MAX(255), .PREADY_TIMEOUT(16), .SPTEF_BIT(5), .SPIF_BIT(7)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cfg_start_i(cfg_start_i), .cfg_cr1_i(cfg_cr1_i),
    .cfg_cr2_i(cfg_cr2_i), .cfg_br_i(cfg_br_i), .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i),
    .tx_ready_o(tx_ready_o), .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .busy_o(busy_o),
    .cfg_done_o(cfg_done_o), .err_o(err_o), .PADDR_o(PADDR_o), .PSEL_o(PSEL_o),
    .PENABLE_o(PENABLE_o), .PWRITE_o(PWRITE_o), .PWDATA_o(PWDATA_o), .PRDATA_i(PRDATA_i),
    .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i)
  );

  typedef struct {logic [2:0] addr; logic wr; logic [7:0] data;} txn_t;
  txn_t       exp_q[$];
  logic [7:0] sr_q[$], dr_q[$];
  int         n_chk = 0, n_pass = 0;
  bit         ws_rand = 0, stuck = 0, slverr_drw = 0;
  int         sr_reads = 0, acc_cnt = 0, rx_cnt = 0, ws = 0;
  logic [7:0] last_rx = '0, rx_exp_d = '0;
  bit         prev_psel = 0, done_prev = 0, rx_exp = 0, done_nx, rx_nx;
  txn_t       cur, e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
  endtask

  // APB slave + per-cycle compare; samples outputs and drives at negedge.
  initial begin : slave
    PREADY_i = 1'b0; PRDATA_i = '0; PSLVERR_i = 1'b0;
    forever begin
      @(negedge PCLK);
      done_nx = 0; rx_nx = 0;
      if (PRESET) begin
        prev_psel = 0; done_prev = 0; rx_exp = 0;
        PREADY_i = 1'b0;
        continue;
      end
      if (done_prev) check("apb_idle_after_xfer", {PSEL_o, PENABLE_o}, 2'b00);
      check("rx_valid", rx_valid_o, rx_exp);
      if (rx_exp) check("rx_data", rx_data_o, rx_exp_d);
      if (rx_valid_o) begin rx_cnt++; last_rx = rx_data_o; end
      check("ready_eq_cfg_done", tx_ready_o, cfg_done_o);
      if (PSEL_o) check("busy_during_xfer", {busy_o, tx_ready_o}, 2'b10);
      if (PENABLE_o) check("penable_needs_psel", PSEL_o, 1'b1);
      PREADY_i = 1'b0; PSLVERR_i = 1'($urandom); PRDATA_i = 8'($urandom);
      if (PSEL_o && !PENABLE_o) begin
        check("setup_after_idle", prev_psel, 1'b0);
        cur.addr = PADDR_o; cur.wr = PWRITE_o; cur.data = PWDATA_o;
        ws = ws_rand ? $urandom_range(0, 2) : 0;
        acc_cnt = 0;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_xfer: addr %0h wr %0b, required none", PADDR_o, PWRITE_o);
        end else begin
          e = exp_q.pop_front();
          check("xfer_addr", PADDR_o, e.addr);
          check("xfer_dir", PWRITE_o, e.wr);
          if (e.wr) check("xfer_wdata", PWDATA_o, e.data);
        end
      end else if (PSEL_o && PENABLE_o) begin
        check("access_stable", {PADDR_o, PWRITE_o, PWDATA_o}, {cur.addr, cur.wr, cur.data});
        acc_cnt++;
        if (stuck) ;
        else if (ws > 0) ws--;
        else begin
          PREADY_i = 1'b1; done_nx = 1;
          if (cur.wr) PSLVERR_i = slverr_drw && (cur.addr == ADDR_DR);
          else begin
            PSLVERR_i = 1'b0;
            if (cur.addr == ADDR_SR) begin
              PRDATA_i = 8'h00;
              if (sr_q.size() > 0) PRDATA_i = sr_q.pop_front();
              sr_reads++;
            end else if (cur.addr == ADDR_DR) begin
              PRDATA_i = 8'h00;
              if (dr_q.size() > 0) PRDATA_i = dr_q.pop_front();
              rx_nx = 1; rx_exp_d = PRDATA_i;
            end
          end
        end
      end
      prev_psel = PSEL_o; done_prev = done_nx; rx_exp = rx_nx;
    end
  end

  function automatic txn_t t(input logic [2:0] a, input logic w, input logic [7:0] d);
    txn_t x; x.addr = a; x.wr = w; x.data = d; return x;
  endfunction

  task automatic wait_cond(input string nm, input int which, input int bound);
    int n = 0;
    bit c;
    c = (which == 0) ? tx_ready_o : (which == 1) ? err_o : (PSEL_o & PENABLE_o);
    while (!c && n < bound) begin
      @(negedge PCLK); n++;
      c = (which == 0) ? tx_ready_o : (which == 1) ? err_o : (PSEL_o & PENABLE_o);
    end
    if (!c) begin n_chk++; $display("FAIL %s: condition not seen in %0d cycles, required within bound", nm, bound); end
  endtask

  task automatic do_cfg(input logic [7:0] c1, c2, b, output int lat);
    exp_q.push_back(t(ADDR_CR1, 1, c1));
    exp_q.push_back(t(ADDR_CR2, 1, c2));
    exp_q.push_back(t(ADDR_BR, 1, b));
    cfg_cr1_i = c1; cfg_cr2_i = c2; cfg_br_i = b;
    cfg_start_i = 1'b1;
    @(negedge PCLK); cfg_start_i = 1'b0;
    check("cfg_clears_err", err_o, 1'b0);
    check("cfg_busy", busy_o, 1'b1);
    lat = 0;
    while (!cfg_done_o && lat < 60) begin @(negedge PCLK); lat++; end
  endtask

  task automatic handshake(input logic [7:0] d);
    int n = 0;
    tx_valid_i = 1'b1; tx_data_i = d;
    while (!tx_ready_o && n < 4000) begin @(negedge PCLK); n++; end
    if (!tx_ready_o) begin n_chk++; $display("FAIL handshake: tx_ready_o 0 for %0d cycles, required 1", n); end
    @(negedge PCLK);
    tx_valid_i = 1'b0; tx_data_i = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] d, input int na, input int nb, input logic [7:0] rx);
    for (int i = 0; i < na; i++) sr_q.push_back(8'($urandom) & ~8'h20);
    sr_q.push_back(8'($urandom) | 8'h20);
    for (int i = 0; i < nb; i++) sr_q.push_back(8'($urandom) & ~8'h80);
    sr_q.push_back(8'($urandom) | 8'h80);
    dr_q.push_back(rx);
    for (int i = 0; i <= na; i++) exp_q.push_back(t(ADDR_SR, 0, 0));
    exp_q.push_back(t(ADDR_DR, 1, d));
    for (int i = 0; i <= nb; i++) exp_q.push_back(t(ADDR_SR, 0, 0));
    exp_q.push_back(t(ADDR_DR, 0, 0));
    handshake(d);
  endtask

  initial begin : wdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, s0, r0;
    repeat (3) @(negedge PCLK);
    check("rst_apb", {PSEL_o, PENABLE_o}, 2'b00);
    check("rst_flags", {busy_o, err_o, tx_ready_o, cfg_done_o, rx_valid_o}, 5'b0);
    PRESET = 1'b0;
    @(negedge PCLK);

    do_cfg(8'hFB, 8'hD0, 8'h01, lat);
    check("cfg_latency", lat, 9);
    check("cfg_ready", {cfg_done_o, tx_ready_o, busy_o}, 3'b110);

    // cfg_start while READY must do nothing
    cfg_start_i = 1'b1; @(negedge PCLK); cfg_start_i = 1'b0;
    @(negedge PCLK);
    check("start_ignored_in_ready", tx_ready_o, 1'b1);

    s0 = sr_reads;
    sr_q = '{8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    dr_q.push_back(8'hAB);
    repeat (3) exp_q.push_back(t(ADDR_SR, 0, 0));
    exp_q.push_back(t(ADDR_DR, 1, 8'hAA));
    repeat (5) exp_q.push_back(t(ADDR_SR, 0, 0));
    exp_q.push_back(t(ADDR_DR, 0, 0));
    handshake(8'hAA);
    wait_cond("byte_done", 0, 400);
    check("directed_sr_reads", sr_reads - s0, 8);
    check("directed_rx", last_rx, 8'hAB);
    check("directed_rx_cnt", rx_cnt, 1);
    check("directed_all_xfers", exp_q.size(), 0);

    ws_rand = 1;
    for (int k = 0; k < 24; k++)
      send_byte(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom));
    wait_cond("random_done", 0, 400);
    check("random_rx_cnt", rx_cnt, 25);
    check("random_all_xfers", exp_q.size(), 0);
    ws_rand = 0;

    // slave error on the DR write
    slverr_drw = 1; r0 = rx_cnt;
    sr_q.push_back(8'h20);
    exp_q.push_back(t(ADDR_SR, 0, 0));
    exp_q.push_back(t(ADDR_DR, 1, 8'h5C));
    handshake(8'h5C);
    wait_cond("slverr_err", 1, 100);
    check("slverr_flags", {err_o, tx_ready_o, busy_o, cfg_done_o}, 4'b1000);
    check("slverr_no_rx", rx_cnt, r0);
    slverr_drw = 0;
    do_cfg(8'h12, 8'h34, 8'h56, lat);
    check("recfg_latency", lat, 9);

    // PREADY stuck low on an SR read
    stuck = 1;
    exp_q.push_back(t(ADDR_SR, 0, 0));
    handshake(8'h77);
    wait_cond("timeout_err", 1, 200);
    check("timeout_access_cycles", acc_cnt, 16);
    check("timeout_dropped", {PSEL_o, err_o, busy_o}, 3'b010);
    stuck = 0;
    do_cfg(8'h01, 8'h02, 8'h03, lat);

    // SR never reports SPTEF: exactly 255 reads then error
    s0 = sr_reads;
    repeat (255) exp_q.push_back(t(ADDR_SR, 0, 0));
    handshake(8'h99);
    wait_cond("poll_err", 1, 2000);
    repeat (10) @(negedge PCLK);
    check("poll_reads", sr_reads - s0, 255);
    check("poll_all_xfers", exp_q.size(), 0);
    check("poll_flags", {err_o, busy_o, tx_ready_o}, 3'b100);
    do_cfg(8'hA5, 8'h5A, 8'h0F, lat);

    // reset in the middle of an ACCESS phase
    stuck = 1;
    exp_q.push_back(t(ADDR_SR, 0, 0));
    handshake(8'h3C);
    wait_cond("reach_access", 2, 50);
    @(negedge PCLK);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("rst_abort_apb", {PSEL_o, PENABLE_o}, 2'b00);
    @(negedge PCLK); @(negedge PCLK);
    check("rst_mid_flags", {busy_o, err_o, tx_ready_o, cfg_done_o, rx_valid_o}, 5'b0);
    PRESET = 1'b0; stuck = 0;
    @(negedge PCLK);
    do_cfg(8'h11, 8'h22, 8'h33, lat);
    check("post_rst_cfg_latency", lat, 9);
    send_byte(8'hC3, 1, 2, 8'h3D);
    wait_cond("final_byte", 0, 400);
    check("final_rx", last_rx, 8'h3D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
